tlb_op_sequencer: RTL and testbench
===================================

Name: tlb_op_sequencer

Overview:
- Sequences the CP0 TLB maintenance instructions TLBP, TLBR, TLBWI and TLBWR onto the shared TLB probe, read and write ports of mmu_top.
- Sits between the WB/CP0 stage and the MMU.
- Owns the Random register, counting down from ENTRIES-1 toward Wired.
- Gives the pipeline a ready/done handshake and an abort path for late exceptions.

Parameters:
ENTRIES, 16, number of TLB entries; must be a power of two, at least 4.
IDX_W, 4, index width, equal to log2(ENTRIES).
CFG_W, 90, width of one TLB entry configuration word, matching tlb_config.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  TLB op request from the pipeline
op_type  in  2  00=TLBP, 01=TLBR, 10=TLBWI, 11=TLBWR
op_ready  out  1  sequencer idle; request is accepted when op_valid && op_ready
op_done  out  1  one-cycle pulse when the op completes
op_flush  in  1  abort the in-flight op (exception in WB)
cp0_index  in  IDX_W  CP0 Index register
cp0_wired  in  IDX_W  CP0 Wired register
cp0_wired_we  in  1  Wired is being written this cycle
cp0_entry_cfg  in  CFG_W  EntryHi/Lo0/Lo1/PageMask packed config
cp0_vpn2  in  19  EntryHi VPN2 to probe
cp0_asid  in  8  EntryHi ASID to probe
tlb_probe  out  1  probe strobe to the TLB
tlb_probe_vpn2  out  19  probe VPN2
tlb_probe_asid  out  8  probe ASID
tlb_probe_result  in  32  TLB probe result: bit31 = miss, [IDX_W-1:0] = hit index; valid the cycle after the strobe
tlb_rindex  out  IDX_W  read index
tlb_rdata  in  CFG_W  read data; valid the cycle after tlb_rindex is presented
tlb_we  out  1  write strobe
tlb_windex  out  IDX_W  write index
tlb_wdata  out  CFG_W  write data
probe_result  out  32  latched TLBP result for CP0 Index
rd_data  out  CFG_W  latched TLBR result for CP0
random  out  IDX_W  CP0 Random register

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state=IDLE; op_ready=1; op_done=0.
  - tlb_probe=0, tlb_we=0; all index and data outputs 0.
  - probe_result=32'h8000_0000; rd_data=0; random=ENTRIES-1.
  - Reset mid-op abandons the op with no write.
- States: IDLE, PROBE, PCAPT, READ, RCAPT, WRITE.
- On accept, in IDLE at cycle T:
  - Latch op_type, cp0_index, cp0_entry_cfg, cp0_vpn2, cp0_asid.
  - Latch the write index: cp0_index for TLBWI, the current random for TLBWR.
  - Later changes on the cp0_* inputs do not affect the op.
  - Go to PROBE, READ or WRITE.
- TLBP:
  - T+1 (PROBE): tlb_probe=1, latched vpn2 and asid driven.
  - T+2 (PCAPT): probe_result <= tlb_probe_result; op_done=1; go to IDLE.
- TLBR:
  - T+1 (READ): tlb_rindex = latched index.
  - T+2 (RCAPT): rd_data <= tlb_rdata; op_done=1; go to IDLE.
- TLBWI/TLBWR:
  - T+1 (WRITE): tlb_we=1 with latched windex and wdata; op_done=1 in the same cycle; go to IDLE.
- op_ready=1 only in IDLE.
  - Back-to-back ops: the next accept can happen the cycle after op_done.
  - Throughput is one op per 2 cycles for writes, one per 3 cycles for TLBP/TLBR.
- tlb_probe and tlb_we are single-cycle strobes, 0 in all other states.
- op_flush:
  - Sampled in every non-IDLE state; if high, go to IDLE next cycle.
  - op_done is not asserted and probe_result/rd_data are not updated.
  - In WRITE, flush suppresses tlb_we combinationally in that same cycle.
  - Flush in IDLE has no effect; a request with op_valid && op_flush in IDLE is not accepted.
- Random register, updated every cycle regardless of state:
  - If cp0_wired_we: random <= ENTRIES-1.
  - Else if random <= cp0_wired, or random == 0: random <= ENTRIES-1.
  - Else: random <= random-1.
  - If cp0_wired >= ENTRIES-1, random holds at ENTRIES-1.
  - Random is never below cp0_wired for more than one cycle after Wired changes.
- TLBWR uses the random value sampled at accept, not the value in the WRITE cycle.
- No combinational path from op_valid to any TLB strobe. op_ready is a registered-state decode.

Test Plan:
- Reset, then idle for 20 cycles with wired=0 → random sequence 15,14,…,1,0,15; probe_result=32'h8000_0000; op_ready=1.
- TLBP with vpn2=19'h00123, asid=8'h05; TLB returns 32'h0000_0007 the cycle after the strobe → tlb_probe high exactly at T+1, op_done at T+2, probe_result=32'h0000_0007.
- TLBWI with cp0_index=3, cfg=90'hABC; cp0_index changed to 9 at T+1 → tlb_we at T+1 with windex=3, wdata=90'hABC; op_done at T+1.
- wired=12: random cycles 15,14,13,12,15. TLBWR accepted when random=13 → tlb_windex=13. Then cp0_wired_we pulse → random=15 the next cycle.
- TLBR index=5, tlb_rdata=90'h1234 → rd_data=90'h1234 at T+2. Immediate back-to-back TLBP is accepted the cycle after op_done.
- TLBWI with op_flush high in the WRITE cycle → tlb_we=0, no op_done, state IDLE next cycle. TLBP flushed in PCAPT → probe_result unchanged. rst_n low during READ → all outputs reset asynchronously.

Source files
------------

// File: rtl/tlb_op_sequencer.sv
// ============================================================================
// tlb_op_sequencer
//
// Purpose:
//   Sequences the CP0 TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR)
//   onto the shared probe/read/write ports of the MMU TLB. It sits between the
//   WB/CP0 stage and the MMU, owns the CP0 Random register, offers the pipeline
//   a ready/done handshake and lets a late WB exception abort the in-flight op.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   op_valid/op_type    TLB op request (00=TLBP 01=TLBR 10=TLBWI 11=TLBWR)
//   op_ready            high only while idle; accept = op_valid && op_ready
//   op_done             one-cycle completion pulse
//   op_flush            aborts the in-flight op (ignored while idle, and it
//                       blocks acceptance of a request presented alongside it)
//   cp0_index/cp0_wired/cp0_wired_we
//                       CP0 Index, Wired and the Wired write strobe
//   cp0_entry_cfg       packed EntryHi/Lo0/Lo1/PageMask configuration word
//   cp0_vpn2/cp0_asid   EntryHi fields used by TLBP
//   tlb_probe*          probe strobe, key, and result (result is valid one
//                       cycle after the strobe)
//   tlb_rindex/tlb_rdata read index and data (data valid one cycle later)
//   tlb_we/windex/wdata write strobe, index and data
//   probe_result        TLBP result latched for CP0 Index
//   rd_data             TLBR result latched for CP0
//   random              CP0 Random register
// ============================================================================
module tlb_op_sequencer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int CFG_W   = 90
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    output logic             op_ready,
    output logic             op_done,
    input  logic             op_flush,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             cp0_wired_we,
    input  logic [CFG_W-1:0] cp0_entry_cfg,
    input  logic [18:0]      cp0_vpn2,
    input  logic [7:0]       cp0_asid,
    output logic             tlb_probe,
    output logic [18:0]      tlb_probe_vpn2,
    output logic [7:0]       tlb_probe_asid,
    input  logic [31:0]      tlb_probe_result,
    output logic [IDX_W-1:0] tlb_rindex,
    input  logic [CFG_W-1:0] tlb_rdata,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_windex,
    output logic [CFG_W-1:0] tlb_wdata,
    output logic [31:0]      probe_result,
    output logic [CFG_W-1:0] rd_data,
    output logic [IDX_W-1:0] random
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_PCAPT,
        S_READ,
        S_RCAPT,
        S_WRITE
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    localparam logic [IDX_W-1:0] RANDOM_TOP = IDX_W'(ENTRIES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             probe_cap;
    logic             rd_cap;

    // Operands captured at accept time so that CP0 can move on underneath us.
    // A single index register serves both read and write: TLBR/TLBWI use
    // Index, TLBWR uses the Random value current at accept.
    logic [IDX_W-1:0] op_index;
    logic [CFG_W-1:0] op_cfg;
    logic [18:0]      op_vpn2;
    logic [7:0]       op_asid;

    // A flush presented together with a request vetoes the accept.
    assign accept = (state == S_IDLE) && op_valid && !op_flush;

    assign tlb_probe_vpn2 = op_vpn2;
    assign tlb_probe_asid = op_asid;
    assign tlb_rindex     = op_index;
    assign tlb_windex     = op_index;
    assign tlb_wdata      = op_cfg;

    // State register. Dropping rst_n mid-op simply returns to IDLE; the write
    // strobe is a state decode, so an abandoned write never reaches the TLB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode. Every busy state looks at op_flush: a
    // flushed op heads straight back to IDLE without op_done or any capture,
    // and in WRITE the flush also kills tlb_we within the same cycle.
    // Nothing here depends on op_valid except the IDLE transition, so no
    // strobe has a combinational path from the request.
    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        op_done   = 1'b0;
        tlb_probe = 1'b0;
        tlb_we    = 1'b0;
        probe_cap = 1'b0;
        rd_cap    = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (accept) begin
                    case (op_type)
                        OP_TLBP:            state_nxt = S_PROBE;
                        OP_TLBR:            state_nxt = S_READ;
                        OP_TLBWI, OP_TLBWR: state_nxt = S_WRITE;
                        default:            state_nxt = S_IDLE;
                    endcase
                end
            end
            S_PROBE: begin
                tlb_probe = 1'b1;
                state_nxt = op_flush ? S_IDLE : S_PCAPT;
            end
            S_PCAPT: begin
                state_nxt = S_IDLE;
                if (!op_flush) begin
                    op_done   = 1'b1;
                    probe_cap = 1'b1;
                end
            end
            S_READ: begin
                state_nxt = op_flush ? S_IDLE : S_RCAPT;
            end
            S_RCAPT: begin
                state_nxt = S_IDLE;
                if (!op_flush) begin
                    op_done = 1'b1;
                    rd_cap  = 1'b1;
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
                if (!op_flush) begin
                    op_done = 1'b1;
                    tlb_we  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept. TLBWR freezes Random here, so the entry it
    // replaces is the one Random pointed at when the instruction retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_index <= '0;
            op_cfg   <= '0;
            op_vpn2  <= '0;
            op_asid  <= '0;
        end else if (accept) begin
            op_index <= (op_type == OP_TLBWR) ? random : cp0_index;
            op_cfg   <= cp0_entry_cfg;
            op_vpn2  <= cp0_vpn2;
            op_asid  <= cp0_asid;
        end
    end

    // Result registers seen by CP0. probe_result resets to "miss" so a TLBP
    // that never completed reads back as not found.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_result <= 32'h8000_0000;
            rd_data      <= '0;
        end else begin
            if (probe_cap) begin
                probe_result <= tlb_probe_result;
            end
            if (rd_cap) begin
                rd_data <= tlb_rdata;
            end
        end
    end

    // Random counts down every cycle from the top entry toward Wired and wraps
    // back to the top once it reaches Wired (or zero). A Wired write restarts
    // it at the top; if Wired covers the top entry, Random simply parks there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random <= RANDOM_TOP;
        end else if (cp0_wired_we || (random <= cp0_wired) || (random == '0)) begin
            random <= RANDOM_TOP;
        end else begin
            random <= random - IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// ============================================================================
// tb_tlb_op_sequencer
//
// Scoreboarded bench for tlb_op_sequencer. A driver issues directed and
// randomized TLB ops and pushes the expected completion into a queue; a
// monitor on the falling edge pops and compares whenever op_done appears, and
// tracks Random and the CP0-visible result registers every cycle. The TLB is
// emulated by a responder with a small entry array and a fixed probe lookup.
// ============================================================================
module tb_tlb_op_sequencer;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int CFG_W   = 90;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             op_valid;
    logic [1:0]       op_type;
    logic             op_ready;
    logic             op_done;
    logic             op_flush;
    logic [IDX_W-1:0] cp0_index;
    logic [IDX_W-1:0] cp0_wired;
    logic             cp0_wired_we;
    logic [CFG_W-1:0] cp0_entry_cfg;
    logic [18:0]      cp0_vpn2;
    logic [7:0]       cp0_asid;
    logic             tlb_probe;
    logic [18:0]      tlb_probe_vpn2;
    logic [7:0]       tlb_probe_asid;
    logic [31:0]      tlb_probe_result;
    logic [IDX_W-1:0] tlb_rindex;
    logic [CFG_W-1:0] tlb_rdata;
    logic             tlb_we;
    logic [IDX_W-1:0] tlb_windex;
    logic [CFG_W-1:0] tlb_wdata;
    logic [31:0]      probe_result;
    logic [CFG_W-1:0] rd_data;
    logic [IDX_W-1:0] random;

    typedef struct {
        logic [1:0]       kind;
        logic [IDX_W-1:0] windex;
        logic [CFG_W-1:0] wdata;
        logic [31:0]      presult;
        logic [CFG_W-1:0] rresult;
    } exp_t;

    exp_t             exp_q[$];
    int               vectors     = 0;
    int               miscompares = 0;

    logic [CFG_W-1:0] tlb_mem   [ENTRIES];
    logic [CFG_W-1:0] model_mem [ENTRIES];
    int               model_random;
    logic [31:0]      exp_probe;
    logic [CFG_W-1:0] exp_rd;
    logic             pend_probe;
    logic [31:0]      pend_probe_val;
    logic             pend_rd;
    logic [CFG_W-1:0] pend_rd_val;

    tlb_op_sequencer #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .CFG_W   (CFG_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .op_valid         (op_valid),
        .op_type          (op_type),
        .op_ready         (op_ready),
        .op_done          (op_done),
        .op_flush         (op_flush),
        .cp0_index        (cp0_index),
        .cp0_wired        (cp0_wired),
        .cp0_wired_we     (cp0_wired_we),
        .cp0_entry_cfg    (cp0_entry_cfg),
        .cp0_vpn2         (cp0_vpn2),
        .cp0_asid         (cp0_asid),
        .tlb_probe        (tlb_probe),
        .tlb_probe_vpn2   (tlb_probe_vpn2),
        .tlb_probe_asid   (tlb_probe_asid),
        .tlb_probe_result (tlb_probe_result),
        .tlb_rindex       (tlb_rindex),
        .tlb_rdata        (tlb_rdata),
        .tlb_we           (tlb_we),
        .tlb_windex       (tlb_windex),
        .tlb_wdata        (tlb_wdata),
        .probe_result     (probe_result),
        .rd_data          (rd_data),
        .random           (random)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed probe lookup used both by the TLB stand-in and for expectations.
    function automatic logic [31:0] probeLookup(input logic [18:0] vpn2, input logic [7:0] asid);
        return {vpn2[4] ^ asid[4], 27'd0, vpn2[3:0] ^ asid[3:0] ^ 4'h1};
    endfunction

    function automatic logic [CFG_W-1:0] randCfg();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[CFG_W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TLB stand-in: registered probe result and read data, write on tlb_we.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tlb_mem[i] <= '0;
            tlb_probe_result <= 32'h5A5A_5A5A;
            tlb_rdata        <= '0;
        end else begin
            tlb_probe_result <= tlb_probe ? probeLookup(tlb_probe_vpn2, tlb_probe_asid) : 32'h5A5A_5A5A;
            tlb_rdata        <= tlb_mem[tlb_rindex];
            if (tlb_we) tlb_mem[tlb_windex] <= tlb_wdata;
        end
    end

    // Reference Random: walks down one per cycle, back to the top entry on a
    // Wired write, on reaching Wired, or after zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_random = ENTRIES - 1;
        end else if (cp0_wired_we || model_random <= int'(cp0_wired) || model_random == 0) begin
            model_random = ENTRIES - 1;
        end else begin
            model_random = model_random - 1;
        end
    end

    // Monitor: compares Random and result registers every cycle and pops the
    // scoreboard whenever the DUT reports a completion.
    always @(negedge clk) begin
        exp_t rec;
        if (rst_n) begin
            if (pend_probe) begin
                exp_probe  = pend_probe_val;
                pend_probe = 1'b0;
            end
            if (pend_rd) begin
                exp_rd  = pend_rd_val;
                pend_rd = 1'b0;
            end
            checkOutput("random", random, model_random[IDX_W-1:0]);
            checkOutput("probe_result", probe_result, exp_probe);
            checkOutput("rd_data", rd_data, exp_rd);
            if (op_done) begin
                checkOutput("done_has_request", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    rec = exp_q.pop_front();
                    if (rec.kind[1]) begin
                        checkOutput("tlb_we_at_done", tlb_we, 1);
                        checkOutput("tlb_windex", tlb_windex, rec.windex);
                        checkOutput("tlb_wdata", tlb_wdata, rec.wdata);
                    end else begin
                        checkOutput("tlb_we_quiet", tlb_we, 0);
                        if (rec.kind == OP_TLBP) begin
                            pend_probe     = 1'b1;
                            pend_probe_val = rec.presult;
                        end else begin
                            pend_rd     = 1'b1;
                            pend_rd_val = rec.rresult;
                        end
                    end
                end
            end else begin
                checkOutput("we_without_done", tlb_we, 0);
            end
        end
    end

    // Issues one op from the idle point (#1 after a rising edge) and returns
    // at the same point once the sequencer is idle again. flush_stage selects
    // the busy cycle (1 or 2) in which op_flush is raised, 0 for none.
    task automatic applyStimulus(input logic [1:0] kind, input logic [IDX_W-1:0] idx,
                                 input logic [CFG_W-1:0] cfg, input logic [18:0] vpn2,
                                 input logic [7:0] asid, input int flush_stage);
        exp_t rec;
        checkOutput("op_ready_idle", op_ready, 1);
        cp0_index     = idx;
        cp0_entry_cfg = cfg;
        cp0_vpn2      = vpn2;
        cp0_asid      = asid;
        op_type       = kind;
        op_flush      = 1'b0;
        op_valid      = 1'b1;
        rec.kind      = kind;
        rec.windex    = (kind == OP_TLBWR) ? model_random[IDX_W-1:0] : idx;
        rec.wdata     = cfg;
        rec.presult   = probeLookup(vpn2, asid);
        rec.rresult   = model_mem[idx];
        if (flush_stage == 0) begin
            exp_q.push_back(rec);
            if (kind[1]) model_mem[rec.windex] = cfg;
        end
        @(posedge clk);
        #1;
        op_valid      = 1'b0;
        cp0_index     = IDX_W'($urandom_range(0, ENTRIES - 1));
        cp0_entry_cfg = randCfg();
        cp0_vpn2      = 19'($urandom());
        cp0_asid      = 8'($urandom());
        op_flush      = (flush_stage == 1);
        #1;
        checkOutput("op_ready_busy", op_ready, 0);
        case (kind)
            OP_TLBP: begin
                if (flush_stage != 1) begin
                    checkOutput("probe_strobe", tlb_probe, 1);
                    checkOutput("probe_vpn2", tlb_probe_vpn2, vpn2);
                    checkOutput("probe_asid", tlb_probe_asid, asid);
                end
            end
            OP_TLBR: begin
                checkOutput("read_index", tlb_rindex, idx);
                checkOutput("read_no_strobes", {tlb_probe, tlb_we}, 0);
            end
            default: begin
                checkOutput("write_strobe", tlb_we, flush_stage == 0);
                checkOutput("write_done", op_done, flush_stage == 0);
                checkOutput("write_no_probe", tlb_probe, 0);
            end
        endcase
        @(posedge clk);
        #1;
        op_flush = 1'b0;
        if (!kind[1]) begin
            checkOutput("capt_strobes_low", {tlb_probe, tlb_we}, 0);
            op_flush = (flush_stage == 2);
            @(posedge clk);
            #1;
            op_flush = 1'b0;
        end
    endtask

    task automatic pulseWired(input logic [IDX_W-1:0] w);
        cp0_wired    = w;
        cp0_wired_we = 1'b1;
        @(posedge clk);
        #1;
        cp0_wired_we = 1'b0;
    endtask

    task automatic runRandomOp();
        logic [1:0] kind;
        int         fs;
        int         r;
        if ($urandom_range(0, 7) == 0) pulseWired(IDX_W'($urandom_range(0, ENTRIES - 1)));
        kind = 2'($urandom_range(0, 3));
        r    = $urandom_range(0, 9);
        fs   = (r < 7) ? 0 : (kind[1] ? 1 : $urandom_range(1, 2));
        applyStimulus(kind, IDX_W'($urandom_range(0, ENTRIES - 1)), randCfg(),
                      19'($urandom()), 8'($urandom()), fs);
    endtask

    task automatic clearModel();
        exp_q.delete();
        pend_probe = 1'b0;
        pend_rd    = 1'b0;
        exp_probe  = 32'h8000_0000;
        exp_rd     = '0;
        for (int i = 0; i < ENTRIES; i++) model_mem[i] = '0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_op_ready", op_ready, 1);
        checkOutput("rst_op_done", op_done, 0);
        checkOutput("rst_strobes", {tlb_probe, tlb_we}, 0);
        checkOutput("rst_rindex", tlb_rindex, 0);
        checkOutput("rst_windex", tlb_windex, 0);
        checkOutput("rst_wdata", tlb_wdata, 0);
        checkOutput("rst_probe_key", {tlb_probe_vpn2, tlb_probe_asid}, 0);
        checkOutput("rst_probe_result", probe_result, 32'h8000_0000);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_random", random, ENTRIES - 1);
    endtask

    initial begin
        rst_n         = 1'b1;
        op_valid      = 1'b0;
        op_type       = 2'b00;
        op_flush      = 1'b0;
        cp0_index     = '0;
        cp0_wired     = '0;
        cp0_wired_we  = 1'b0;
        cp0_entry_cfg = '0;
        cp0_vpn2      = '0;
        cp0_asid      = '0;
        clearModel();
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkResetState();
        rst_n = 1'b1;

        // Idle with Wired = 0: Random walks 15 down to 0 and wraps.
        repeat (20) begin
            @(posedge clk);
            #1;
        end

        applyStimulus(OP_TLBP, 4'd0, '0, 19'h00123, 8'h05, 0);
        applyStimulus(OP_TLBWI, 4'd3, 90'hABC, 19'h0, 8'h0, 0);

        // Wired = 12: TLBWR taken when Random reads 13, then a Wired write.
        pulseWired(4'd12);
        for (int i = 0; i < 20 && model_random != 13; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("random_reached_13", random, 13);
        applyStimulus(OP_TLBWR, 4'd1, 90'h3_0000_0000_0000_0000_5555, 19'h0, 8'h0, 0);
        pulseWired(4'd12);
        pulseWired(4'd0);

        // Read back a known entry, then a back-to-back probe.
        applyStimulus(OP_TLBWI, 4'd5, 90'h1234, 19'h0, 8'h0, 0);
        applyStimulus(OP_TLBR, 4'd5, '0, 19'h0, 8'h0, 0);
        applyStimulus(OP_TLBP, 4'd0, '0, 19'h00456, 8'h33, 0);

        // Flushes in each busy state.
        applyStimulus(OP_TLBWI, 4'd7, randCfg(), 19'h0, 8'h0, 1);
        applyStimulus(OP_TLBR, 4'd7, '0, 19'h0, 8'h0, 0);
        applyStimulus(OP_TLBP, 4'd0, '0, 19'h7FFFF, 8'hFF, 2);
        applyStimulus(OP_TLBP, 4'd0, '0, 19'h12345, 8'h11, 1);
        applyStimulus(OP_TLBR, 4'd5, '0, 19'h0, 8'h0, 2);
        applyStimulus(OP_TLBR, 4'd5, '0, 19'h0, 8'h0, 1);

        // A request arriving with a flush while idle must be ignored.
        op_valid = 1'b1;
        op_type  = OP_TLBWI;
        op_flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_idle_not_accepted", op_ready, 1);
        op_valid = 1'b0;
        op_flush = 1'b0;

        for (int n = 0; n < 300; n++) runRandomOp();

        // Asynchronous reset in the middle of a TLBR.
        cp0_index = 4'd6;
        op_type   = OP_TLBR;
        op_valid  = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        checkOutput("read_index_before_reset", tlb_rindex, 6);
        rst_n = 1'b0;
        #1;
        checkResetState();
        clearModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 10; n++) runRandomOp();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
